// File: rtl/score_tracker_pkg.sv
// +----------------------------------------------------------------------------+
// | score_pkg : shared types and constants for the runner score tracker         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package score_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    OVER   = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // Packed BCD pattern with the lowest 'digits' digits at 9, zero above.
  function automatic logic [31:0] bcd_all_nines(input int digits);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < digits) v[4*i +: 4] = BCD_MAX;
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/score_tracker_if.sv
// +----------------------------------------------------------------------------+
// | score_tracker_if : game-control / display bundle for score_tracker          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface score_tracker_if #(
  parameter int DIGITS  = 4,
  parameter int LEVEL_W = 3
);
  logic                  start;
  logic                  pause;
  logic                  crash;
  logic [4*DIGITS-1:0]   score;
  logic [4*DIGITS-1:0]   high_score;
  logic [LEVEL_W-1:0]    level;
  logic                  running;
  logic                  new_record;
  logic                  saturated;
  logic                  point_tick;

  modport master (
    output start, pause, crash,
    input  score, high_score, level, running, new_record, saturated, point_tick
  );

  modport slave (
    input  start, pause, crash,
    output score, high_score, level, running, new_record, saturated, point_tick
  );
endinterface

`default_nettype wire

// File: rtl/score_tracker_bcd_digit.sv
// +----------------------------------------------------------------------------+
// | bcd_digit : one decimal digit of the score counter with ripple carry       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module bcd_digit
  import score_pkg::*;
(
  input  wire logic clk3,
  input  wire logic reset,
  input  wire logic i_clear,
  input  wire logic i_inc,
  input  wire logic i_en,
  output bcd_t      o_digit,
  output logic      o_carry
);

  bcd_t r_digit;

  assign o_digit = r_digit;
  assign o_carry = i_inc && (r_digit == BCD_MAX);

  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      r_digit <= '0;
    end else if (i_clear) begin
      r_digit <= '0;
    end else if (i_inc && i_en) begin
      r_digit <= (r_digit == BCD_MAX) ? '0 : r_digit + 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/score_tracker.sv
// +----------------------------------------------------------------------------+
// | score_tracker : run-state FSM, BCD score, high score and difficulty level  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module score_tracker
  import score_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int PERIOD     = 2,
  parameter int LEVEL_STEP = 100,
  parameter int LEVEL_W    = 3
) (
  input  wire logic       clk3,
  input  wire logic       reset,
  score_tracker_if.slave  bus
);

  localparam int PRE_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int LC_W  = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;
  localparam int SW    = 4 * DIGITS;

  localparam logic [31:0]        c_nines32   = bcd_all_nines(DIGITS);
  localparam logic [SW-1:0]      c_nines     = c_nines32[SW-1:0];
  localparam logic [LEVEL_W-1:0] c_lvl_max   = '1;
  localparam logic [PRE_W-1:0]   c_pre_last  = PRE_W'(PERIOD - 1);
  localparam logic [LC_W-1:0]    c_lc_last   = LC_W'(LEVEL_STEP - 1);

  state_t               r_state;
  logic [PRE_W-1:0]     r_presc;
  logic [LC_W-1:0]      r_lvl_cnt;
  logic [LEVEL_W-1:0]   r_level;
  logic [SW-1:0]        r_high;
  logic                 r_running;
  logic                 r_new_record;
  logic                 r_point_tick;

  logic [SW-1:0]        w_score;
  logic [DIGITS:0]      w_carry;
  logic                 w_begin;
  logic                 w_end;
  logic                 w_advance;
  logic                 w_wrap;
  logic                 w_inc;

  assign w_begin   = bus.start && (r_state == IDLE || r_state == OVER);
  assign w_end     = bus.crash && (r_state == RUN || r_state == PAUSED);
  assign w_advance = (r_state == RUN) && !bus.crash && !bus.pause;
  assign w_wrap    = w_advance && (r_presc == c_pre_last);

  // A carry out of the top digit means the score is all 9s: suppress the step.
  assign w_carry[0] = w_wrap;
  assign w_inc      = w_wrap && !w_carry[DIGITS];

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digits
    bcd_digit u_digit (
      .clk3    (clk3),
      .reset   (reset),
      .i_clear (w_begin),
      .i_inc   (w_carry[gi]),
      .i_en    (!w_carry[DIGITS]),
      .o_digit (w_score[4*gi +: 4]),
      .o_carry (w_carry[gi+1])
    );
  end

  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_presc      <= '0;
      r_lvl_cnt    <= '0;
      r_level      <= '0;
      r_high       <= '0;
      r_running    <= 1'b0;
      r_new_record <= 1'b0;
      r_point_tick <= 1'b0;
    end else begin
      r_point_tick <= w_inc;

      // Packed BCD is MSB-ordered, so a plain unsigned compare orders scores.
      if (w_end) begin
        if (w_score > r_high) begin
          r_high       <= w_score;
          r_new_record <= 1'b1;
        end else begin
          r_new_record <= 1'b0;
        end
      end

      case (r_state)
        IDLE, OVER: begin
          if (bus.start) begin
            r_state      <= RUN;
            r_running    <= 1'b1;
            r_presc      <= '0;
            r_lvl_cnt    <= '0;
            r_level      <= '0;
            r_new_record <= 1'b0;
          end
        end
        RUN: begin
          if (bus.crash) begin
            r_state   <= OVER;
            r_running <= 1'b0;
          end else if (bus.pause) begin
            r_state   <= PAUSED;
            r_running <= 1'b0;
          end else begin
            r_presc <= (r_presc == c_pre_last) ? '0 : r_presc + 1'b1;
            if (w_inc) begin
              if (r_lvl_cnt == c_lc_last) begin
                r_lvl_cnt <= '0;
                if (r_level != c_lvl_max) r_level <= r_level + 1'b1;
              end else begin
                r_lvl_cnt <= r_lvl_cnt + 1'b1;
              end
            end
          end
        end
        PAUSED: begin
          if (bus.crash) begin
            r_state   <= OVER;
            r_running <= 1'b0;
          end else if (!bus.pause) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign bus.score      = w_score;
  assign bus.high_score = r_high;
  assign bus.level      = r_level;
  assign bus.running    = r_running;
  assign bus.new_record = r_new_record;
  assign bus.saturated  = (w_score == c_nines);
  assign bus.point_tick = r_point_tick;

endmodule

`default_nettype wire
